// File: rtl/dram_row_controller.sv
// Row-level front end for the burst DRAM model.
// A write row is split into BURST_LEN beats, and read beats are assembled back into a row.
// Each accepted request produces exactly one response pulse.
// That pulse carries an error flag on timeout or on a wrong beat count.
module dram_row_controller #(
  parameter  int ADDR_W         = 16,
  parameter  int BEAT_W         = 64,
  parameter  int BURST_LEN      = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ROW_W          = BEAT_W * BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ROW_W-1:0]  req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [ROW_W-1:0]  resp_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_read_en,
  output logic              dram_write_en,
  output logic [BEAT_W-1:0] dram_wdata,
  input  logic              dram_ready,
  input  logic              dram_complete,
  input  logic [BEAT_W-1:0] dram_rdata,
  input  logic              dram_valid
);
  localparam int BIW = $clog2(BURST_LEN + 1);
  localparam int IW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BIW-1:0] BEATS  = BIW'(BURST_LEN);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_RESP} state_e;

  state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             we_q, we_d;
  logic [BURST_LEN-1:0][BEAT_W-1:0] row_q, row_d;
  logic [BIW-1:0]                   beat_idx_q, beat_idx_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic                             cnt_err_q, cnt_err_d;
  logic                             rd_en_q, rd_en_d;
  logic                             wr_en_q, wr_en_d;
  logic                             resp_err_q, resp_err_d;
  logic [IW-1:0]                    beat_slot;
  logic                             beat_in_range;

  // beat_idx saturates at BURST_LEN, so only the low bits ever address the row buffer
  assign beat_slot     = beat_idx_q[IW-1:0];
  assign beat_in_range = (beat_idx_q < BEATS);

  // State and datapath registers; reset abandons any access in flight without responding
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      row_q      <= '0;
      beat_idx_q <= '0;
      timer_q    <= '0;
      cnt_err_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      row_q      <= row_d;
      beat_idx_q <= beat_idx_d;
      timer_q    <= timer_d;
      cnt_err_q  <= cnt_err_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next state: completion wins over timeout when both land in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ISSUE;
      S_ISSUE: if (dram_ready) state_d = S_XFER;
      S_XFER:  if (dram_complete || timer_q == T_LAST) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the request, count beats, and fold any same-cycle beat into the completion error
  always_comb begin
    addr_d     = addr_q;
    we_d       = we_q;
    row_d      = row_q;
    beat_idx_d = beat_idx_q;
    timer_d    = timer_q;
    cnt_err_d  = cnt_err_q;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    resp_err_d = resp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d     = req_addr;
        we_d       = req_we;
        row_d      = req_wdata;
        beat_idx_d = '0;
        timer_d    = '0;
        cnt_err_d  = 1'b0;
        resp_err_d = 1'b0;
      end
      S_ISSUE: if (dram_ready) begin
        rd_en_d = !we_q;
        wr_en_d = we_q;
      end
      S_XFER: begin
        timer_d = timer_q + TW'(1);
        if (dram_valid) begin
          if (beat_in_range) begin
            if (!we_q) row_d[beat_slot] = dram_rdata;
            beat_idx_d = beat_idx_q + BIW'(1);
          end else begin
            cnt_err_d = 1'b1;
          end
        end
        if (dram_complete) begin
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          resp_err_d = cnt_err_d | (beat_idx_d != BEATS);
        end else if (timer_q == T_LAST) begin
          rd_en_d    = 1'b0;
          wr_en_d    = 1'b0;
          resp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: the response is a single-cycle pulse in RESP, and the write beat is combinational
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    resp_valid    = (state_q == S_RESP);
    resp_err      = resp_valid & resp_err_q;
    resp_rdata    = row_q;
    dram_addr     = addr_q;
    dram_read_en  = rd_en_q;
    dram_write_en = wr_en_q;
    dram_wdata    = '0;
    if (state_q == S_XFER && we_q && beat_in_range) dram_wdata = row_q[beat_slot];
  end
endmodule

// File: tb/tb_dram_row_controller.sv
// Randomized bench for dram_row_controller.
// The DRAM side is played by tasks, and responses are predicted from the row-level rules:
// an error results from a timeout or from a beat count other than BURST_LEN,
// and the read row is the latched request row with the first beats replaced by the returned beats.
module tb_dram_row_controller;
  localparam int ADDR_W = 16, BEAT_W = 64, BURST_LEN = 8, TIMEOUT_CYCLES = 1024;
  localparam int ROW_W = BEAT_W * BURST_LEN;
  typedef logic [BURST_LEN-1:0][BEAT_W-1:0] row_t;

  logic clk = 1'b0, rst;
  logic req_valid, req_ready, req_we, resp_valid, resp_err;
  logic [ADDR_W-1:0] req_addr, dram_addr;
  logic [ROW_W-1:0] req_wdata, resp_rdata;
  logic dram_read_en, dram_write_en, dram_ready, dram_complete, dram_valid;
  logic [BEAT_W-1:0] dram_wdata, dram_rdata;

  dram_row_controller #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN),
                        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .dram_addr(dram_addr), .dram_read_en(dram_read_en),
    .dram_write_en(dram_write_en), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
    .dram_complete(dram_complete), .dram_rdata(dram_rdata), .dram_valid(dram_valid));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < BURST_LEN; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // One request end to end: handshake, rdy_dly ISSUE cycles, then nbeats strobes in XFER.
  // When done is set, complete follows the last strobe; otherwise the access runs into the timeout.
  task automatic run_txn(input bit we, input logic [ADDR_W-1:0] addr, input row_t wdata,
                         input row_t rbeats, input int rdy_dly, input int nbeats, input bit done);
    row_t exp_row;
    int sent, cyc;
    bit fin, cmpl;
    logic [BEAT_W-1:0] beat;
    exp_row = wdata;
    sent = 0; cyc = 0; fin = 0; cmpl = 0;
    chk("idle_ready", req_ready, 1'b1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    dram_ready = 0; dram_valid = 1'($urandom); dram_complete = 1'($urandom);
    tick;
    // Scramble the request bus so that only latched values can produce a correct result
    req_valid = 0; req_addr = ADDR_W'($urandom); req_wdata = rand_row(); req_we = 1'($urandom);
    for (int i = 0; i < rdy_dly; i++) begin
      chk("issue_ready", req_ready, 1'b0);
      chk("issue_en", {dram_read_en, dram_write_en}, 2'b00);
      dram_valid = 1'($urandom); dram_complete = 1'($urandom); dram_rdata = {$urandom, $urandom};
      tick;
    end
    chk("issue_ready", req_ready, 1'b0);
    chk("issue_en", {dram_read_en, dram_write_en}, 2'b00);
    dram_ready = 1; dram_valid = 0; dram_complete = 0;
    tick;
    dram_ready = 1'($urandom);
    while (!fin) begin
      chk("xfer_rd_en", dram_read_en, !we);
      chk("xfer_wr_en", dram_write_en, we);
      chk("xfer_addr", dram_addr, addr);
      chk("xfer_no_resp", resp_valid, 1'b0);
      dram_valid = (sent < nbeats) && ($urandom_range(0, 2) != 0);
      if (dram_valid) begin
        beat = (sent < BURST_LEN) ? rbeats[sent] : {$urandom, $urandom};
        dram_rdata = beat;
        if (we) chk("wdata_beat", dram_wdata, (sent < BURST_LEN) ? wdata[sent] : '0);
        if (!we && sent < BURST_LEN) exp_row[sent] = beat;
        sent++;
      end else begin
        dram_rdata = {$urandom, $urandom};
      end
      cmpl = done && (sent == nbeats) && (!dram_valid || ($urandom_range(0, 1) == 1));
      dram_complete = cmpl;
      fin = cmpl || (cyc == TIMEOUT_CYCLES - 1);
      tick;
      cyc++;
    end
    // RESP cycle: DRAM strobes here must be ignored
    dram_valid = 1'($urandom); dram_complete = 1'($urandom);
    chk("resp_valid", resp_valid, 1'b1);
    chk("resp_err", resp_err, !cmpl || (sent != BURST_LEN));
    chk("resp_en_drop", {dram_read_en, dram_write_en}, 2'b00);
    chk("resp_addr", dram_addr, addr);
    if (!we) chk("resp_rdata", resp_rdata, exp_row);
    tick;
    dram_valid = 0; dram_complete = 0;
    chk("resp_pulse", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    row_t rb, wd;
    int nb;
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    dram_ready = 0; dram_complete = 0; dram_rdata = '0; dram_valid = 0;
    tick; tick;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp", {resp_valid, resp_err}, 2'b00);
    chk("rst_en", {dram_read_en, dram_write_en}, 2'b00);
    chk("rst_addr", dram_addr, '0);
    chk("rst_wdata", dram_wdata, '0);
    chk("rst_rdata", resp_rdata, '0);
    rst = 0;

    // Read row 0x0012 returning beats 0x11..0x88
    for (int i = 0; i < BURST_LEN; i++) rb[i] = BEAT_W'((i + 1) * 'h11);
    run_txn(0, 16'h0012, rand_row(), rb, 0, 8, 1);
    // Write row 0x0003 with beat i = i+1
    for (int i = 0; i < BURST_LEN; i++) wd[i] = BEAT_W'(i + 1);
    run_txn(1, 16'h0003, wd, rand_row(), 0, 8, 1);
    // DRAM busy for 20 cycles after the handshake
    run_txn(0, 16'h0100, rand_row(), rand_row(), 20, 8, 1);
    // DRAM never completes, for a read and for a write
    run_txn(0, 16'h0200, rand_row(), rand_row(), 1, 3, 0);
    run_txn(1, 16'h0201, rand_row(), rand_row(), 0, 8, 0);
    // Short and long bursts
    run_txn(0, 16'h0300, rand_row(), rand_row(), 0, 6, 1);
    run_txn(0, 16'h0301, rand_row(), rand_row(), 2, 10, 1);
    run_txn(1, 16'h0302, rand_row(), rand_row(), 0, 10, 1);
    run_txn(1, 16'h0303, rand_row(), rand_row(), 0, 0, 1);

    // Reset in the middle of a read
    req_valid = 1; req_we = 0; req_addr = 16'h0055; req_wdata = rand_row();
    tick;
    req_valid = 0; dram_ready = 1;
    tick;
    chk("pre_rst_en", dram_read_en, 1'b1);
    for (int i = 0; i < 3; i++) begin
      dram_valid = 1; dram_rdata = {$urandom, $urandom};
      tick;
    end
    dram_valid = 0; rst = 1;
    tick;
    rst = 0;
    chk("mid_rst_en", {dram_read_en, dram_write_en}, 2'b00);
    chk("mid_rst_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_resp", resp_valid, 1'b0);
      tick;
    end
    run_txn(0, 16'h0056, rand_row(), rand_row(), 1, 8, 1);

    // Random traffic, mostly well-formed bursts
    for (int t = 0; t < 40; t++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : BURST_LEN;
      run_txn(1'($urandom), ADDR_W'($urandom), rand_row(), rand_row(),
              $urandom_range(0, 5), nb, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
